pc_update: RTL and testbench

//   Y86-64 sequential-core PC-update stage: selects the next program counter

---
 rtl/y86_pkg.sv | 20 ++
 rtl/pc_update_if.sv | 22 ++
 rtl/pc_next_sel.sv | 34 +++
 rtl/pc_update.sv | 42 ++++
 tb/tb_pc_update.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes and default datapath width.
package y86_pkg;

    localparam int ADDR_W_DEFAULT = 64;
    localparam int ICODE_W        = 4;

    localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
    localparam logic [ICODE_W-1:0] INOP    = 4'h1;
    localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
    localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
    localparam logic [ICODE_W-1:0] IRET    = 4'h9;
    localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/pc_update_if.sv
// Bundle of the PC-update stage operands and its registered result.
// master = upstream datapath driving operands, slave = the PC-update stage.
interface pc_update_if #(
    parameter int ADDR_W = y86_pkg::ADDR_W_DEFAULT
);
    logic [y86_pkg::ICODE_W-1:0] icode;
    logic                        cnd;
    logic [ADDR_W-1:0]           valC;
    logic [ADDR_W-1:0]           valP;
    logic [ADDR_W-1:0]           valM;
    logic [ADDR_W-1:0]           updated_pc;

    modport master (
        output icode, cnd, valC, valP, valM,
        input  updated_pc
    );

    modport slave (
        input  icode, cnd, valC, valP, valM,
        output updated_pc
    );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector for the Y86-64 SEQ PC-update stage.
// Optional feature macro: PC_UPDATE_HALT_HOLD_EN (halt freezes the PC).
module pc_next_sel
    import y86_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ICODE_W-1:0] icode,
    input  logic               cnd,
    input  logic [ADDR_W-1:0]  valC,
    input  logic [ADDR_W-1:0]  valP,
    input  logic [ADDR_W-1:0]  valM,
`ifdef PC_UPDATE_HALT_HOLD_EN
    input  logic [ADDR_W-1:0]  cur_pc,
`endif
    output logic [ADDR_W-1:0]  next_pc
);

    // Pick the next PC source from the instruction class; cnd matters only for jXX.
    always_comb begin
        // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
        next_pc = valP;
        case (icode)
            ICALL:   next_pc = valC;
            IJXX:    next_pc = cnd ? valC : valP;
            IRET:    next_pc = valM;
`ifdef PC_UPDATE_HALT_HOLD_EN
            IHALT:   next_pc = cur_pc;
`endif
            default: next_pc = valP;
        endcase
    end

endmodule

// File: rtl/pc_update.sv
// Y86-64 SEQ PC-update stage: registers the selected next PC and feeds it back to fetch.
// Optional feature macro: PC_UPDATE_HALT_HOLD_EN (halt freezes the PC instead of taking valP).
module pc_update
    import y86_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    pc_update_if.slave    bus
);

    logic [ADDR_W-1:0] next_pc_d;
    logic [ADDR_W-1:0] updated_pc_q;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_sel (
        .icode   (bus.icode),
        .cnd     (bus.cnd),
        .valC    (bus.valC),
        .valP    (bus.valP),
        .valM    (bus.valM),
`ifdef PC_UPDATE_HALT_HOLD_EN
        .cur_pc  (updated_pc_q),
`endif
        .next_pc (next_pc_d)
    );

    // Capture the selected PC on each rising edge; reset clears it immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            updated_pc_q <= '0;
        end else begin
            updated_pc_q <= next_pc_d;
        end
    end

    assign bus.updated_pc = updated_pc_q;

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: directed cases followed by randomized
// instructions compared against a behavioural next-PC model.
// Honours PC_UPDATE_HALT_HOLD_EN the same way as the design.
module tb_pc_update;

    localparam int ADDR_W = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [ADDR_W-1:0] exp_pc;

    pc_update_if #(.ADDR_W(ADDR_W)) bus ();

    pc_update #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef PC_UPDATE_HALT_HOLD_EN
    localparam bit HALT_HOLDS = 1'b1;
`else
    localparam bit HALT_HOLDS = 1'b0;
`endif

    // Behavioural reference: where does the program go after this instruction?
    function automatic logic [ADDR_W-1:0] model_next(
        input logic [3:0]        ic,
        input logic              c,
        input logic [ADDR_W-1:0] vc,
        input logic [ADDR_W-1:0] vp,
        input logic [ADDR_W-1:0] vm,
        input logic [ADDR_W-1:0] cur
    );
        bit is_call  = (ic == 4'd8);
        bit is_jump  = (ic == 4'd7);
        bit is_ret   = (ic == 4'd9);
        bit is_halt  = (ic == 4'd0);
        if (is_call || (is_jump && c)) return vc;
        if (is_ret)                    return vm;
        if (is_halt && HALT_HOLDS)     return cur;
        return vp;
    endfunction

    task automatic check(input string tag, input logic [ADDR_W-1:0] obs,
                         input logic [ADDR_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [3:0] ic, input logic c,
                              input logic [ADDR_W-1:0] vc,
                              input logic [ADDR_W-1:0] vp,
                              input logic [ADDR_W-1:0] vm);
        bus.icode = ic;
        bus.cnd   = c;
        bus.valC  = vc;
        bus.valP  = vp;
        bus.valM  = vm;
    endtask

    // Apply one instruction (called just after an edge), clock it, check 1 time unit later.
    task automatic step(input string tag, input logic [3:0] ic, input logic c,
                        input logic [ADDR_W-1:0] vc, input logic [ADDR_W-1:0] vp,
                        input logic [ADDR_W-1:0] vm);
        set_inputs(ic, c, vc, vp, vm);
        @(posedge clk);
        exp_pc = model_next(ic, c, vc, vp, vm, exp_pc);
        #1;
        check(tag, bus.updated_pc, exp_pc);
    endtask

    initial begin
        logic [3:0]        r_ic;
        logic              r_c;
        logic [ADDR_W-1:0] r_vc, r_vp, r_vm;

        n_checks = 0;
        n_errors = 0;
        exp_pc   = '0;

        // 1. Reset clears the PC without an edge and holds it across edges.
        reset = 1'b1;
        set_inputs(4'd8, 1'b1, 64'h1111, 64'h2222, 64'h3333);
        #2;
        check("reset_no_edge", bus.updated_pc, 64'd0);
        @(posedge clk); #1;
        check("reset_edge1", bus.updated_pc, 64'd0);
        @(posedge clk); #1;
        check("reset_edge2", bus.updated_pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_pc = 64'h1111;
        check("first_capture_after_release", bus.updated_pc, exp_pc);

        // 2-5. Directed instruction classes.
        step("call",          4'd8, 1'b0, 64'd1,  64'd3,  64'd2);
        step("jxx_not_taken", 4'd7, 1'b0, 64'd12, 64'd3,  64'd15);
        step("jxx_taken",     4'd7, 1'b1, 64'd12, 64'd3,  64'd15);
        step("ret",           4'd9, 1'b1, 64'd24, 64'd10, 64'd15);
        step("opq_cnd_ignored", 4'd6, 1'b1, 64'd24, 64'd10, 64'd15);
        step("halt",          4'd0, 1'b1, 64'd24, 64'h20, 64'd15);
        step("halt_again",    4'd0, 1'b0, 64'd99, 64'h40, 64'd77);
        step("invalid_icode_f", 4'hF, 1'b1, 64'd5, 64'h30, 64'd6);
        step("call_all_ones", 4'd8, 1'b0, '1, 64'd0, 64'd0);
        step("pushq_zero",    4'hA, 1'b1, '1, 64'd0, '1);

        // 6. Input changes between edges do not reach the output.
        step("before_mid_change", 4'd8, 1'b0, 64'hABCD, 64'h10, 64'h20);
        set_inputs(4'd9, 1'b1, 64'h5, 64'h6, 64'h7);
        #2;
        check("mid_cycle_hold", bus.updated_pc, exp_pc);
        @(negedge clk);
        check("negedge_hold", bus.updated_pc, exp_pc);
        @(posedge clk);
        exp_pc = 64'h7;
        #1;
        check("after_mid_change", bus.updated_pc, exp_pc);

        // Reset asserted mid-cycle clears immediately.
        #2;
        reset = 1'b1;
        #1;
        exp_pc = '0;
        check("reset_mid_cycle", bus.updated_pc, exp_pc);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_pc = 64'h7;
        check("capture_after_mid_reset", bus.updated_pc, exp_pc);

        // Randomized instructions with occasional asynchronous reset pulses.
        for (int i = 0; i < 300; i++) begin
            r_ic = 4'($urandom_range(0, 15));
            r_c  = 1'($urandom);
            r_vc = {$urandom, $urandom};
            r_vp = {$urandom, $urandom};
            r_vm = {$urandom, $urandom};
            step("random", r_ic, r_c, r_vc, r_vp, r_vm);
            if (i % 60 == 59) begin
                #2;
                reset = 1'b1;
                #1;
                exp_pc = '0;
                check("random_reset", bus.updated_pc, exp_pc);
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
